// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// ALU control codes and the datapath select codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StJalr,
        StJlink,
        StLui,
        StError
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    // Must match the datapath ALU encoding.
    localparam logic [2:0] AluAdd   = 3'b000;
    localparam logic [2:0] AluSub   = 3'b001;
    localparam logic [2:0] AluAnd   = 3'b010;
    localparam logic [2:0] AluOr    = 3'b011;
    localparam logic [2:0] AluPassB = 3'b100;
    localparam logic [2:0] AluSltu  = 3'b101;
    localparam logic [2:0] AluSlt   = 3'b110;
    localparam logic [2:0] AluXor   = 3'b111;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;
    localparam logic [1:0] AluOpPassB = 2'b11;

    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResMem    = 2'b01;
    localparam logic [1:0] ResAluRes = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        logic [2:0] sel;
        case (op)
            OpStore:  sel = ImmS;
            OpBranch: sel = ImmB;
            OpJal:    sel = ImmJ;
            OpLui:    sel = ImmU;
            default:  sel = ImmI;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALU operation class plus funct fields onto the
// datapath ALU control code; flags funct3 values this core does not execute.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] alu_control_o,
    output logic       bad_funct_o
);

    always_comb begin
        alu_control_o = AluAdd;
        bad_funct_o   = 1'b0;
        case (alu_op_i)
            AluOpAdd:   alu_control_o = AluAdd;
            AluOpSub:   alu_control_o = AluSub;
            AluOpPassB: alu_control_o = AluPassB;
            default: begin
                case (funct3_i)
                    // op5 separates R-type from OP-IMM: addi never subtracts.
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? AluSub : AluAdd;
                    3'b010:  alu_control_o = AluSlt;
                    3'b011:  alu_control_o = AluSltu;
                    3'b100:  alu_control_o = AluXor;
                    3'b110:  alu_control_o = AluOr;
                    3'b111:  alu_control_o = AluAnd;
                    default: bad_funct_o   = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/writeback sequencing with
// wait-state memory handshake, driving datapath selects, strobes and ALU control.
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       lt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [2:0] alu_control,
    output logic       instr_done,
    output logic       illegal
);

    state_e     state_q, state_d;
    logic       illegal_q;
    logic [1:0] alu_op;
    logic [2:0] alu_ctrl_dec;
    logic       bad_funct;
    logic       taken;

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .op5_i         (opcode[5]),
        .alu_control_o (alu_ctrl_dec),
        .bad_funct_o   (bad_funct)
    );

    always_comb begin
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        case (state_q)
            StExecR, StExecI: alu_op = AluOpFunct;
            StBranch:         alu_op = AluOpSub;
            StLui:            alu_op = AluOpPassB;
            default:          alu_op = AluOpAdd;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpReg:           state_d = StExecR;
                    OpImm:           state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    OpLui:           state_d = StLui;
                    default:         state_d = StError;
                endcase
            end
            StMemAdr:         state_d = opcode[5] ? StMemWrite : StMemRead;
            StMemRead:        if (mem_ready) state_d = StMemWb;
            StMemWb:          state_d = StFetch;
            StMemWrite:       if (mem_ready) state_d = StFetch;
            StExecR, StExecI: state_d = bad_funct ? StError : StAluWb;
            StAluWb:          state_d = StFetch;
            StBranch:         state_d = StFetch;
            StJal:            state_d = StAluWb;
            StJalr:           state_d = StJlink;
            StJlink:          state_d = StFetch;
            StLui:            state_d = StAluWb;
            StError:          state_d = StError;
            default:          state_d = StError;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == StError);
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        result_src = ResAluOut;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBRs2;
        case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                alu_src_b  = SrcBFour;
                result_src = ResAluRes;
            end
            StDecode: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            StMemWb: begin
                result_src = ResMem;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StMemWrite: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                instr_done = mem_ready;
            end
            StExecR: alu_src_a = SrcARs1;
            StExecI: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
            end
            StAluWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                alu_src_a  = SrcARs1;
                pc_write   = taken;
                instr_done = 1'b1;
            end
            StJal: begin
                pc_write  = 1'b1;
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBFour;
            end
            StJalr: begin
                alu_src_a  = SrcARs1;
                alu_src_b  = SrcBImm;
                result_src = ResAluRes;
                pc_write   = 1'b1;
            end
            StJlink: begin
                alu_src_a  = SrcAOldPc;
                alu_src_b  = SrcBFour;
                result_src = ResAluRes;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StLui: alu_src_b = SrcBImm;
            default: ;
        endcase
        // Reset overrides the FETCH decode so nothing reaches the datapath while held.
        if (!rst_n) begin
            mem_req    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            result_src = ResAluOut;
            alu_src_a  = SrcAPc;
            alu_src_b  = SrcBRs2;
        end
    end

    assign alu_control = rst_n ? alu_ctrl_dec : AluAdd;
    assign imm_src     = rst_n ? imm_sel(opcode) : ImmI;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction expected cycle sequences built from the
// instruction class, compared every cycle, plus randomized instruction streams.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5, zero, lt, mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src, alu_control;
    logic       instr_done, illegal;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .lt          (lt),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_write   (mem_write),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .instr_done  (instr_done),
        .illegal     (illegal)
    );

    // One expected cycle. Flags: mem = repeats until mem_ready, fetch = ir/pc write follow
    // mem_ready, wdone = done follows mem_ready, aludc = alu_control unspecified, err = terminal.
    typedef struct packed {
        logic [16:0] v;
        logic        mem;
        logic        fetch;
        logic        wdone;
        logic        aludc;
        logic        err;
    } step_t;

    step_t q[$];

    // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, result_src, a, b, alu, done, ill}
    function automatic logic [16:0] mk(input logic mreq, input logic mw, input logic adr,
                                       input logic pcw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic done, input logic ill);
        return {mreq, mw, adr, 1'b0, pcw, rw, rs, sa, sb, alu, done, ill};
    endfunction

    function automatic step_t st(input logic [16:0] v, input logic mem, input logic fetch,
                                 input logic wdone, input logic aludc, input logic err);
        step_t s;
        s.v = v; s.mem = mem; s.fetch = fetch; s.wdone = wdone; s.aludc = aludc; s.err = err;
        return s;
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            7'b0110111: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic f7, input logic is_r);
        case (f3)
            3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b110;
            3'b011:  return 3'b101;
            3'b100:  return 3'b111;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic taken_of(input logic [2:0] f3, input logic z, input logic l);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return l;
            3'b101:  return !l;
            default: return 1'b0;
        endcase
    endfunction

    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input logic l);
        logic [16:0] aluwb, errv;
        logic        shift;
        aluwb = mk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 1, 0);
        errv  = mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 1);
        shift = (f3 == 3'b001) || (f3 == 3'b101);
        q.delete();
        q.push_back(st(mk(1, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 0, 0), 1, 1, 0, 0, 0));
        q.push_back(st(mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, 0, 0), 0, 0, 0, 0, 0));
        case (op)
            7'b0000011, 7'b0100011: begin
                q.push_back(st(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 0, 0), 0, 0, 0, 0, 0));
                if (op[5])
                    q.push_back(st(mk(1, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 0), 1, 0, 1, 0, 0));
                else begin
                    q.push_back(st(mk(1, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 0), 1, 0, 0, 0, 0));
                    q.push_back(st(mk(0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd0, 1, 0), 0, 0, 0, 0, 0));
                end
            end
            7'b0110011, 7'b0010011: begin
                q.push_back(st(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, op[5] ? 2'd0 : 2'd1,
                                  alu_of(f3, f7, op[5]), 0, 0), 0, 0, 0, shift, 0));
                q.push_back(st(shift ? errv : aluwb, 0, 0, 0, 0, shift));
            end
            7'b1100011:
                q.push_back(st(mk(0, 0, 0, taken_of(f3, z, l), 0, 2'd0, 2'd2, 2'd0, 3'd1, 1, 0),
                               0, 0, 0, 0, 0));
            7'b1101111: begin
                q.push_back(st(mk(0, 0, 0, 1, 0, 2'd0, 2'd1, 2'd2, 3'd0, 0, 0), 0, 0, 0, 0, 0));
                q.push_back(st(aluwb, 0, 0, 0, 0, 0));
            end
            7'b1100111: begin
                q.push_back(st(mk(0, 0, 0, 1, 0, 2'd2, 2'd2, 2'd1, 3'd0, 0, 0), 0, 0, 0, 0, 0));
                q.push_back(st(mk(0, 0, 0, 0, 1, 2'd2, 2'd1, 2'd2, 3'd0, 1, 0), 0, 0, 0, 0, 0));
            end
            7'b0110111: begin
                q.push_back(st(mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 3'd4, 0, 0), 0, 0, 0, 0, 0));
                q.push_back(st(aluwb, 0, 0, 0, 0, 0));
            end
            default: q.push_back(st(errv, 0, 0, 0, 0, 1));
        endcase
    endtask

    task automatic check(input step_t s, input logic ready, input int idx);
        logic [16:0] e, a, m;
        e = s.v;
        m = '1;
        if (s.fetch) begin e[13] = ready; e[12] = ready; end
        if (s.wdone) e[1] = ready;
        if (s.aludc) m[4:2] = 3'b000;
        a = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, result_src,
             alu_src_a, alu_src_b, alu_control, instr_done, illegal};
        nvec++;
        if (((a & m) !== (e & m)) || (imm_src !== imm_of(opcode))) begin
            nerr++;
            $display("FAIL cycle op=%b f3=%b step%0d: got %05h imm %b, want %05h imm %b",
                     opcode, funct3, idx, a & m, imm_src, e & m, imm_of(opcode));
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        nvec++;
        if ({mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, result_src, alu_src_a,
             alu_src_b, imm_src, alu_control, instr_done, illegal} !== 20'd0) begin
            nerr++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, result_src,
                      alu_src_a, alu_src_b, imm_src, alu_control, instr_done, illegal});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // fw/mw: forced wait counts in FETCH / data access, -1 for random.
    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input logic l, input int fw, input int mw,
                       input bit abort, output int cycles, output int irw_cnt,
                       output int rw_cnt, output bit ended_err);
        int   i, waits, nw;
        logic ready;
        build(op, f3, f7, z, l);
        cycles = 0; irw_cnt = 0; rw_cnt = 0; ended_err = 0;
        i = 0; waits = 0;
        nw = (fw < 0) ? int'($urandom_range(0, 2)) : fw;
        while (i < q.size()) begin
            @(negedge clk);
            if (cycles == 0) begin
                opcode = op; funct3 = f3; funct7b5 = f7; zero = z; lt = l;
            end
            ready = q[i].mem ? logic'(waits >= nw) : 1'($urandom);
            mem_ready = ready;
            #1;
            check(q[i], ready, i);
            cycles++;
            if (ir_write) irw_cnt++;
            if (reg_write) rw_cnt++;
            if (q[i].err) begin
                ended_err = 1;
                repeat (3) begin
                    @(negedge clk);
                    mem_ready = 1'($urandom);
                    #1;
                    check(q[i], mem_ready, i);
                end
                return;
            end
            if (abort && q[i].mem && !q[i].fetch && !ready) begin
                rst_n = 1'b0;
                #1;
                lit("abort_mem_write", int'(mem_write), 0);
                lit("abort_mem_req", int'(mem_req), 0);
                return;
            end
            if (!q[i].mem || ready) begin
                i++;
                waits = 0;
                nw = (mw < 0) ? int'($urandom_range(0, 2)) : mw;
            end else begin
                waits++;
            end
        end
    endtask

    int        c, irw, rw;
    bit        e;
    logic [2:0] bf3s [6];

    initial begin
        bf3s = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; funct3 = '0;
        funct7b5 = 1'b0; zero = 1'b0; lt = 1'b0;
        do_reset();

        run(7'b0110011, 3'b000, 1'b0, 0, 0, 0, 0, 0, c, irw, rw, e);
        lit("add_cycles", c, 4);
        run(7'b0110011, 3'b000, 1'b1, 0, 0, 0, 0, 0, c, irw, rw, e);
        lit("sub_cycles", c, 4);
        run(7'b0010011, 3'b000, 1'b1, 0, 0, 0, 0, 0, c, irw, rw, e);
        lit("addi_cycles", c, 4);
        run(7'b1100011, 3'b000, 1'b0, 1, 0, 0, 0, 0, c, irw, rw, e);
        lit("beq_cycles", c, 3);
        run(7'b1100011, 3'b101, 1'b0, 0, 1, 0, 0, 0, c, irw, rw, e);
        lit("bge_cycles", c, 3);
        run(7'b1100011, 3'b100, 1'b0, 0, 1, 0, 0, 0, c, irw, rw, e);
        lit("blt_cycles", c, 3);
        run(7'b0000011, 3'b010, 1'b0, 0, 0, 2, 3, 0, c, irw, rw, e);
        lit("lw_wait_cycles", c, 10);
        lit("lw_ir_write_pulses", irw, 1);
        lit("lw_reg_write_cycles", rw, 1);
        run(7'b1100111, 3'b000, 1'b0, 0, 0, 0, 0, 0, c, irw, rw, e);
        lit("jalr_cycles", c, 4);
        run(7'b0100011, 3'b010, 1'b0, 0, 0, 0, 0, 0, c, irw, rw, e);
        lit("sw_cycles", c, 4);
        run(7'b1101111, 3'b000, 1'b0, 0, 0, 0, 0, 0, c, irw, rw, e);
        lit("jal_cycles", c, 4);
        run(7'b0110111, 3'b000, 1'b0, 0, 0, 0, 0, 0, c, irw, rw, e);
        lit("lui_cycles", c, 4);

        run(7'b1111111, 3'b000, 1'b0, 0, 0, 0, 0, 0, c, irw, rw, e);
        lit("bad_opcode_illegal", int'(illegal), 1);
        do_reset();
        lit("illegal_cleared", int'(illegal), 0);
        run(7'b0010011, 3'b001, 1'b0, 0, 0, 0, 0, 0, c, irw, rw, e);
        lit("slli_illegal", int'(illegal), 1);
        do_reset();

        run(7'b0100011, 3'b010, 1'b0, 0, 0, 0, 2, 1, c, irw, rw, e);
        do_reset();
        run(7'b0110011, 3'b111, 1'b0, 0, 0, 0, 0, 0, c, irw, rw, e);
        lit("after_abort_cycles", c, 4);

        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            f3 = 3'($urandom);
            case ($urandom_range(0, 9))
                0: op = 7'b0000011;
                1: op = 7'b0100011;
                2: op = 7'b0110011;
                3: op = 7'b0010011;
                4: begin op = 7'b1100011; f3 = bf3s[$urandom_range(0, 5)]; end
                5: op = 7'b1101111;
                6: op = 7'b1100111;
                7: op = 7'b0110111;
                8: op = 7'($urandom);
                default: op = 7'b0110011;
            endcase
            run(op, f3, 1'($urandom), 1'($urandom), 1'($urandom), -1, -1, 0, c, irw, rw, e);
            if (e) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
